// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM encoding and address helpers
// for the 32-bit-over-16-bit SRAM controller.
package sram_ctrl_pkg;

   localparam int ADDRESS_LEN   = 32;
   localparam int REGISTER_LEN  = 32;
   localparam int SRAM_ADDR_LEN = 18;
   localparam int SRAM_DATA_LEN = 16;
   localparam int WORD_IDX_LEN  = SRAM_ADDR_LEN - 1;
   localparam int CNT_LEN       = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Word index relative to the window base; wraps
   // modulo 2^WORD_IDX_LEN by truncation.
   function automatic logic [WORD_IDX_LEN-1:0] word_index(
      input logic [ADDRESS_LEN-1:0] addr,
      input logic [ADDRESS_LEN-1:0] base
   );
      return WORD_IDX_LEN'((addr - base) >> 2);
   endfunction

   // True when the byte address falls outside the
   // SRAM window (below base, or past the last word).
   function automatic logic out_of_window(
      input logic [ADDRESS_LEN-1:0] addr,
      input logic [ADDRESS_LEN-1:0] base
   );
      logic [ADDRESS_LEN-1:0] word;
      word = (addr - base) >> 2;
      return (addr < base) ||
             (word >= (ADDRESS_LEN'(1) << WORD_IDX_LEN));
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// MEM-stage SRAM controller: splits one 32-bit access
// into two 16-bit SRAM cycles (LO then HI) and freezes
// the pipeline via ready until the access completes.
//
// Ports:
//   clk, rst            clock, sync active-high reset
//   wr_en, rd_en        request from MEM stage
//   address, wdata      byte address, write data
//   rdata, ready        read data, pipeline advance
//   sram_addr           SRAM halfword address
//   sram_dq_out/_in/_oe SRAM data bus and drive enable
//   sram_we_n           active-low write strobe
//   addr_err            out-of-window pulse in DONE
//
// Parameters:
//   WAIT_CYCLES  extra cycles per halfword (0..7)
//   BASE_ADDR    byte address of SRAM word 0
//
// Define SRAM_BOUNDS_CHECK_EN to reject accesses outside
// the SRAM window (IDLE->DONE, addr_err pulse, rdata=0);
// without it the word index simply wraps.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned            WAIT_CYCLES = 1,
   parameter logic [ADDRESS_LEN-1:0] BASE_ADDR   = 32'd1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [ADDRESS_LEN-1:0]   address,
   input  logic [REGISTER_LEN-1:0]  wdata,
   output logic [REGISTER_LEN-1:0]  rdata,
   output logic                     ready,
   output logic [SRAM_ADDR_LEN-1:0] sram_addr,
   output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
   input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
   output logic                     sram_dq_oe,
   output logic                     sram_we_n,
   output logic                     addr_err
);

   localparam logic [CNT_LEN-1:0] CNT_LAST =
      CNT_LEN'(WAIT_CYCLES);

   state_t                  state_q;
   state_t                  state_d;
   logic [CNT_LEN-1:0]      cnt_q;
   logic [WORD_IDX_LEN-1:0] idx_q;
   logic [REGISTER_LEN-1:0] wdata_q;
   logic [REGISTER_LEN-1:0] rdata_q;
   logic [SRAM_DATA_LEN-1:0] lo_q;
   logic                    wr_q;
   logic                    req;
   logic                    req_err;
   logic                    phase_last;

   assign req        = wr_en | rd_en;
   assign phase_last = (cnt_q == CNT_LAST);
   assign rdata      = rdata_q;

`ifdef SRAM_BOUNDS_CHECK_EN
   logic err_q;
   assign req_err = out_of_window(address, BASE_ADDR);
`else
   assign req_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         lo_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               // Request is sampled once here and held;
               // write wins when both enables are high.
               if (req) begin
                  cnt_q   <= '0;
                  idx_q   <= word_index(address, BASE_ADDR);
                  wdata_q <= wdata;
                  wr_q    <= wr_en;
                  if (req_err && !wr_en) begin
                     rdata_q <= '0;
                  end
               end
            end
            LO: begin
               if (phase_last) begin
                  cnt_q <= '0;
                  if (!wr_q) begin
                     lo_q <= sram_dq_in;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HI: begin
               // Low half is staged so rdata only changes
               // when a read fully completes.
               if (phase_last) begin
                  cnt_q <= '0;
                  if (!wr_q) begin
                     rdata_q <= {sram_dq_in, lo_q};
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               cnt_q <= '0;
            end
         endcase
      end
   end

`ifdef SRAM_BOUNDS_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state_q == IDLE && req) begin
         err_q <= req_err;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      addr_err    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Freeze in the arrival cycle of a request.
            ready = ~req;
            if (req) begin
               state_d = req_err ? DONE : LO;
            end
         end
         LO: begin
            sram_addr  = {idx_q, 1'b0};
            sram_dq_oe = wr_q;
            sram_we_n  = ~wr_q;
            if (wr_q) begin
               sram_dq_out = wdata_q[SRAM_DATA_LEN-1:0];
            end
            if (phase_last) begin
               state_d = HI;
            end
         end
         HI: begin
            sram_addr  = {idx_q, 1'b1};
            sram_dq_oe = wr_q;
            sram_we_n  = ~wr_q;
            if (wr_q) begin
               sram_dq_out =
                  wdata_q[REGISTER_LEN-1:SRAM_DATA_LEN];
            end
            if (phase_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Always return to IDLE so a request still
            // held here is not restarted.
            ready   = 1'b1;
            state_d = IDLE;
`ifdef SRAM_BOUNDS_CHECK_EN
            addr_err = err_q;
`endif
         end
      endcase
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: two instances
// (WAIT_CYCLES 1 and 0) against a cycle-count model.
`timescale 1ns/1ps
module tb_sram_ctrl;

   localparam logic [31:0] BASE  = 32'd1024;
   localparam int          NRAND = 150;

   logic clk = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input int inst, input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL w%0d %s actual=%h required=%h t=%0t",
                  inst, name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int W   = (g == 0) ? 1 : 0;
      localparam int LAT = 2 * W + 3;

      logic        rst;
      logic        wr_en;
      logic        rd_en;
      logic [31:0] address;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        ready;
      logic [17:0] sram_addr;
      logic [15:0] sram_dq_out;
      logic [15:0] sram_dq_in;
      logic        sram_dq_oe;
      logic        sram_we_n;
      logic        addr_err;

      logic [15:0] mem   [0:262143];
      logic [15:0] ref_m [0:262143];

      bit          run  = 1'b0;
      bit          done = 1'b0;
      bit          busy = 1'b0;
      int          t    = 0;
      int          lat  = LAT;
      bit          m_wr = 1'b0;
      bit          m_err = 1'b0;
      logic [16:0] m_idx = '0;
      logic [31:0] m_wdata = '0;
      logic [31:0] exp_rdata = '0;

      sram_ctrl #(
         .WAIT_CYCLES(W),
         .BASE_ADDR(BASE)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .wr_en(wr_en),
         .rd_en(rd_en),
         .address(address),
         .wdata(wdata),
         .rdata(rdata),
         .ready(ready),
         .sram_addr(sram_addr),
         .sram_dq_out(sram_dq_out),
         .sram_dq_in(sram_dq_in),
         .sram_dq_oe(sram_dq_oe),
         .sram_we_n(sram_we_n),
         .addr_err(addr_err)
      );

      // Asynchronous SRAM: read through, write on edge.
      assign sram_dq_in = mem[sram_addr];
      always @(posedge clk) begin
         if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
      end

      // Reference: an access occupies cycles 1..lat after
      // its arrival cycle; LO strobes in 1..W+1, HI in
      // W+2..2W+2, completion in cycle lat.
      always @(posedge clk) begin
         if (busy && m_wr && !m_err) begin
            if (t <= W + 1)
               ref_m[{m_idx, 1'b0}] = m_wdata[15:0];
            else if (t <= 2 * W + 2)
               ref_m[{m_idx, 1'b1}] = m_wdata[31:16];
         end
         if (rst) begin
            busy = 1'b0;
            t = 0;
            exp_rdata = '0;
         end else if (!busy) begin
            if (wr_en || rd_en) begin
               busy = 1'b1;
               t = 1;
               m_wr = wr_en;
               m_wdata = wdata;
               m_idx = 17'((address - BASE) >> 2);
               m_err = 1'b0;
`ifdef SRAM_BOUNDS_CHECK_EN
               m_err = (address < BASE) ||
                  (((address - BASE) >> 2) >= 32'h20000);
`endif
               lat = m_err ? 1 : LAT;
               if (m_err && !m_wr) exp_rdata = '0;
            end
         end else if (t == lat) begin
            busy = 1'b0;
         end else begin
            t++;
            if (t == lat && !m_wr)
               exp_rdata = {ref_m[{m_idx, 1'b1}],
                            ref_m[{m_idx, 1'b0}]};
         end
      end

      always @(negedge clk) begin
         logic        e_rdy;
         logic        e_oe;
         logic        e_we;
         logic        e_err;
         logic [17:0] e_addr;
         logic [15:0] e_dq;
         if (run) begin
            e_rdy = 1'b0;
            e_oe = 1'b0;
            e_we = 1'b1;
            e_err = 1'b0;
            e_addr = '0;
            e_dq = '0;
            if (!busy) begin
               e_rdy = !(wr_en || rd_en);
            end else if (t == lat) begin
               e_rdy = 1'b1;
               e_err = m_err;
            end else begin
               e_addr = {m_idx, 1'(t > W + 1)};
               if (m_wr) begin
                  e_oe = 1'b1;
                  e_we = 1'b0;
                  e_dq = (t > W + 1) ? m_wdata[31:16]
                                     : m_wdata[15:0];
               end
            end
            chk(W, "ready", 32'(ready), 32'(e_rdy));
            chk(W, "sram_addr", 32'(sram_addr), 32'(e_addr));
            chk(W, "dq_out", 32'(sram_dq_out), 32'(e_dq));
            chk(W, "dq_oe", 32'(sram_dq_oe), 32'(e_oe));
            chk(W, "we_n", 32'(sram_we_n), 32'(e_we));
            chk(W, "addr_err", 32'(addr_err), 32'(e_err));
            chk(W, "rdata", rdata, exp_rdata);
         end
      end

      // Issue one request and wait (bounded) for ready.
      // Returns cycles from arrival to ready plus the
      // rdata/addr_err seen in that completion cycle.
      task automatic do_req(input bit w, input bit r,
                            input logic [31:0] a,
                            input logic [31:0] d,
                            input bit scr,
                            output int n,
                            output logic [31:0] rv,
                            output logic ev);
         wr_en = w;
         rd_en = r;
         address = a;
         wdata = d;
         n = -1;
         rv = '0;
         ev = 1'b0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) begin
               n = c;
               rv = rdata;
               ev = addr_err;
               break;
            end
            if (scr && c >= 1) begin
               wr_en = 1'($urandom);
               rd_en = 1'($urandom);
               address = $urandom;
               wdata = $urandom;
            end
         end
         if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL w%0d timeout actual=no_ready required=ready",
                     W);
         end
         @(posedge clk);
         #1;
      endtask

      initial begin
         int          n;
         int          bad;
         int          k;
         logic [31:0] a;
         logic [31:0] rv;
         logic        ev;
         for (int i = 0; i < 262144; i++) begin
            mem[i] = 16'($urandom);
            ref_m[i] = mem[i];
         end
         mem[2] = 16'h1234;
         ref_m[2] = 16'h1234;
         mem[3] = 16'hABCD;
         ref_m[3] = 16'hABCD;
         rst = 1'b1;
         wr_en = 1'b0;
         rd_en = 1'b0;
         address = '0;
         wdata = '0;
         repeat (2) @(posedge clk);
         #1;
         run = 1'b1;
         @(negedge clk);
         chk(W, "rst_ready", 32'(ready), 32'd1);
         chk(W, "rst_we_n", 32'(sram_we_n), 32'd1);
         chk(W, "rst_oe", 32'(sram_dq_oe), 32'd0);
         chk(W, "rst_addr", 32'(sram_addr), 32'd0);
         chk(W, "rst_dq", 32'(sram_dq_out), 32'd0);
         chk(W, "rst_rdata", rdata, 32'd0);
         chk(W, "rst_err", 32'(addr_err), 32'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;

         // Write 0xDEADBEEF at word 0.
         wr_en = 1'b1;
         address = BASE;
         wdata = 32'hDEADBEEF;
         for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            chk(W, "wr_ready", 32'(ready),
                (c == LAT) ? 32'd1 : 32'd0);
            if (c == 1) begin
               chk(W, "wr_lo_addr", 32'(sram_addr), 32'd0);
               chk(W, "wr_lo_dq", 32'(sram_dq_out), 32'hBEEF);
               chk(W, "wr_lo_we", 32'(sram_we_n), 32'd0);
            end
            if (c == W + 2) begin
               chk(W, "wr_hi_addr", 32'(sram_addr), 32'd1);
               chk(W, "wr_hi_dq", 32'(sram_dq_out), 32'hDEAD);
               chk(W, "wr_hi_we", 32'(sram_we_n), 32'd0);
            end
         end
         @(posedge clk);
         #1;
         wr_en = 1'b0;

         // Read word 1 (halfwords 2,3).
         do_req(0, 1, BASE + 4, '0, 0, n, rv, ev);
         chk(W, "rd_lat", n, LAT);
         chk(W, "rd_data", rv, 32'hABCD1234);

         // Both enables: write wins, rdata unchanged.
         do_req(1, 1, BASE + 8, 32'h55AA1234, 0, n, rv, ev);
         chk(W, "both_rdata", rdata, 32'hABCD1234);
         chk(W, "both_mem_lo", 32'(mem[4]), 32'h1234);
         chk(W, "both_mem_hi", 32'(mem[5]), 32'h55AA);

         // Back-to-back reads, second held through DONE.
         do_req(0, 1, BASE + 4, '0, 0, n, rv, ev);
         chk(W, "b2b_lat0", n, LAT);
         chk(W, "b2b_data0", rv, 32'hABCD1234);
         do_req(0, 1, BASE + 8, '0, 0, n, rv, ev);
         chk(W, "b2b_lat1", n, LAT);
         chk(W, "b2b_data1", rv, 32'h55AA1234);
         rd_en = 1'b0;
         @(negedge clk);
         chk(W, "b2b_idle_addr", 32'(sram_addr), 32'd0);
         @(posedge clk);
         #1;

         // Reset during the first HI cycle of a write.
         wr_en = 1'b1;
         address = BASE + 16;
         wdata = 32'hCAFEF00D;
         for (int c = 0; c <= W + 2; c++) @(negedge clk);
         chk(W, "hi_addr", 32'(sram_addr), 32'd9);
         chk(W, "hi_we", 32'(sram_we_n), 32'd0);
         rst = 1'b1;
         wr_en = 1'b0;
         @(negedge clk);
         chk(W, "abort_we_n", 32'(sram_we_n), 32'd1);
         chk(W, "abort_oe", 32'(sram_dq_oe), 32'd0);
         chk(W, "abort_rdata", rdata, 32'd0);
         chk(W, "abort_addr", 32'(sram_addr), 32'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;

`ifdef SRAM_BOUNDS_CHECK_EN
         do_req(0, 1, 32'd100, '0, 0, n, rv, ev);
         chk(W, "oob_lat", n, 1);
         chk(W, "oob_err", 32'(ev), 32'd1);
         chk(W, "oob_rdata", rv, 32'd0);
         rd_en = 1'b0;
`endif

         for (int i = 0; i < NRAND; i++) begin
            k = $urandom_range(0, 3);
            a = BASE + 32'(4 * $urandom_range(0, 31)) +
                32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            do_req(k == 0 || k == 3, k != 0, a, $urandom,
                   $urandom_range(0, 3) == 0, n, rv, ev);
            if ($urandom_range(0, 1) == 0) begin
               wr_en = 1'b0;
               rd_en = 1'b0;
               repeat ($urandom_range(1, 3)) begin
                  @(posedge clk);
                  #1;
               end
            end
         end

         wr_en = 1'b0;
         rd_en = 1'b0;
         repeat (3) begin
            @(posedge clk);
            #1;
         end
         bad = 0;
         for (int i = 0; i < 262144; i++)
            if (mem[i] !== ref_m[i]) bad++;
         chk(W, "sram_image", bad, 0);
         done = 1'b1;
      end
   end

   initial begin
      wait (g_inst[0].done && g_inst[1].done);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, extra wait cycles per 16-bit SRAM access; legal range 0..7.
REQ-002 Parameter BASE_ADDR, default 1024, byte address mapped to SRAM word 0.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  write request from MEM stage.
REQ-006 rd_en  in  1  read request from MEM stage.
REQ-007 address  in  32  byte address (ALU result).
REQ-008 wdata  in  32  write data (Rm value).
REQ-009 rdata  out  32  read data, valid while ready=1 in DONE.
REQ-010 ready  out  1  low = pipeline freeze; high = request complete or idle.
REQ-011 sram_addr  out  18  SRAM halfword address.
REQ-012 sram_dq_out  out  16  data driven to SRAM.
REQ-013 sram_dq_in  in  16  data returned from SRAM.
REQ-014 sram_dq_oe  out  1  high = controller drives the SRAM data bus.
REQ-015 sram_we_n  out  1  active-low SRAM write strobe.
REQ-016 addr_err  out  1  one-cycle pulse on out-of-window access (SRAM_BOUNDS_CHECK_EN only; else tied 0).

Function
REQ-017 The FSM SHALL have states IDLE, LO, HI and DONE.
REQ-018 Word index SHALL be (address - BASE_ADDR) >> 2, modulo 2^17; LO uses sram_addr = {index,0}, HI uses {index,1}.
REQ-019 In IDLE, ready SHALL equal ~(wr_en | rd_en), combinationally, so a new request freezes the pipeline in its arrival cycle.
REQ-020 IDLE with a request SHALL go to LO; LO and HI SHALL each last exactly WAIT_CYCLES+1 cycles; HI then goes to DONE; DONE goes to IDLE after one cycle.
REQ-021 In DONE, ready SHALL be 1 and the pipeline advances on that edge; total latency is 2*WAIT_CYCLES+3 cycles from request to ready (5 at default).
REQ-022 Read: sram_dq_in SHALL be captured at the final cycle of LO into rdata[15:0] and of HI into rdata[31:16]; rdata SHALL hold until the next read completes.
REQ-023 Write: during LO and HI, sram_dq_oe=1 and sram_we_n=0, with sram_dq_out = wdata[15:0] in LO and wdata[31:16] in HI.
REQ-024 Outside a write's LO/HI cycles, sram_we_n SHALL be 1 and sram_dq_oe SHALL be 0.
REQ-025 When wr_en and rd_en are both high, the access SHALL be a write and rd_en SHALL be ignored.
REQ-026 Request inputs SHALL be sampled once on leaving IDLE and held internally; input changes while busy SHALL have no effect.
REQ-027 A request still asserted in DONE SHALL NOT restart the FSM; a request present in the IDLE cycle after DONE starts a new access.
REQ-028 The wait counter SHALL be 3 bits and reset to 0 at each phase entry.

Reset
REQ-029 On rst, the controller SHALL enter IDLE with counter=0, rdata=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0 and addr_err=0.
REQ-030 rst mid-access SHALL abort the access at that edge and apply REQ-029; no completion or ready pulse follows.

Configuration
REQ-031 With SRAM_BOUNDS_CHECK_EN defined, a request with address < BASE_ADDR or index >= 2^17 SHALL skip LO and HI and go IDLE->DONE.
REQ-032 Such an access SHALL pulse addr_err in DONE, return rdata=0 for a read, and perform no SRAM strobe.
REQ-033 Without SRAM_BOUNDS_CHECK_EN, no check SHALL be made, the index wraps per REQ-018, and addr_err SHALL be constant 0.

Structure
REQ-034 ADDRESS_LEN, REGISTER_LEN, the SRAM address/data widths and the FSM state encoding SHALL live in the shared defines file.
REQ-035 The design SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-036 Write address 1024, data 0xDEADBEEF, W=1: ready low cycles 0-4; LO writes 0xBEEF at sram_addr 0; HI writes 0xDEAD at 1; ready high in cycle 5.
REQ-037 Read address 1028 with SRAM model holding 0x1234 at 2 and 0xABCD at 3: rdata=0xABCD1234 with ready=1 in cycle 5.
REQ-038 wr_en and rd_en both high: a write occurs and rdata is unchanged.
REQ-039 Assert rst in the HI cycle of a write: next cycle shows IDLE, sram_we_n=1, sram_dq_oe=0, and no ready pulse from that access.
REQ-040 With W=0: back-to-back reads complete in 3 cycles each, and the request held through DONE is not re-executed.
REQ-041 With SRAM_BOUNDS_CHECK_EN, read address 100: DONE after 1 cycle, addr_err=1, rdata=0, sram_we_n never low.
